// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the matching transmitter.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Host-side handshake between the UART receiver and the register block.
interface uart_rx_frame_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  Rx_Read;
    logic [DATA_WIDTH-1:0] Rx_Data;
    logic                  Rx_Data_Ready;
    logic                  Rx_Parity_Error;
    logic                  Rx_Frame_Error;
    logic                  Rx_Overrun;
    logic                  Rx_Busy;

    modport master (
        output Rx_Read,
        input  Rx_Data, Rx_Data_Ready, Rx_Parity_Error, Rx_Frame_Error, Rx_Overrun, Rx_Busy
    );

    modport slave (
        input  Rx_Read,
        output Rx_Data, Rx_Data_Ready, Rx_Parity_Error, Rx_Frame_Error, Rx_Overrun, Rx_Busy
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the serial input; only built when UART_RX_SYNC_EN is defined.
`ifdef UART_RX_SYNC_EN
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [1:0] ff;

    // Resets to the idle line level so no false start bit is seen after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ff <= '1;
        else      ff <= {ff[0], d};
    end

    assign q = ff[1];
endmodule
`endif

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start, DATA_WIDTH bits LSB first, even-XOR parity, stop.
// Define UART_RX_SYNC_EN to pass the serial input through a 2-flop synchronizer.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_W      = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Rx_Enable,
    input  logic            Rx_Serial_Input,
    uart_rx_frame_if.slave  host
);
    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bad;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  ready_q;
    logic                  perr_q;
    logic                  ferr_q;
    logic                  ovr_q;
    logic                  rx_s;

`ifdef UART_RX_SYNC_EN
    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (Rx_Serial_Input),
        .q   (rx_s)
    );
`else
    assign rx_s = Rx_Serial_Input;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
            data_q  <= '0;
            ready_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= 1'b0;

            // Host read clears status; a simultaneous good stop below overrides it.
            if (host.Rx_Read && ready_q) begin
                ready_q <= 1'b0;
                perr_q  <= 1'b0;
                ovr_q   <= 1'b0;
            end

            if (Rx_Enable) begin
                unique case (state)
                    IDLE: begin
                        if (rx_s == START_BIT) begin
                            state <= DATA;
                            cnt   <= '0;
                        end
                    end
                    DATA: begin
                        shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
                        cnt   <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DATA_WIDTH - 1)) state <= PARITY;
                    end
                    PARITY: begin
                        par_bad <= rx_s ^ (^shreg);
                        state   <= STOP;
                    end
                    STOP: begin
                        if (rx_s == STOP_BIT) begin
                            if (!ready_q || host.Rx_Read) begin
                                data_q  <= shreg;
                                ready_q <= 1'b1;
                                perr_q  <= par_bad;
                                ovr_q   <= 1'b0;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                        end else begin
                            ferr_q <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign host.Rx_Data         = data_q;
    assign host.Rx_Data_Ready   = ready_q;
    assign host.Rx_Parity_Error = perr_q;
    assign host.Rx_Frame_Error  = ferr_q;
    assign host.Rx_Overrun      = ovr_q;
    assign host.Rx_Busy         = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomized self-checking bench for uart_rx_frame with a frame-level reference model.
module tb_uart_rx_frame;
    localparam int W = 32;
`ifdef UART_RX_SYNC_EN
    localparam int HOLD = 2;
`else
    localparam int HOLD = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic ser = 1'b1;

    uart_rx_frame_if #(.DATA_WIDTH(W)) host ();

    uart_rx_frame #(.DATA_WIDTH(W), .CNT_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .Rx_Enable       (en),
        .Rx_Serial_Input (ser),
        .host            (host.slave)
    );

    always #5 clk = ~clk;

    // Frame-level model of the externally visible outputs.
    logic [W-1:0] m_data  = '0;
    logic         m_ready = 1'b0;
    logic         m_perr  = 1'b0;
    logic         m_ferr  = 1'b0;
    logic         m_ovr   = 1'b0;
    logic         m_busy  = 1'b0;

    int unsigned vectors  = 0;
    int unsigned errors   = 0;
    bit          check_on = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_on) begin
            chk("data",   host.Rx_Data, m_data);
            chk("ready",  32'(host.Rx_Data_Ready),   32'(m_ready));
            chk("perr",   32'(host.Rx_Parity_Error), 32'(m_perr));
            chk("ferr",   32'(host.Rx_Frame_Error),  32'(m_ferr));
            chk("ovr",    32'(host.Rx_Overrun),      32'(m_ovr));
            chk("busy",   32'(host.Rx_Busy),         32'(m_busy));
        end
    end

    // One clock edge with the given inputs; HOLD pre-cycles keep the bit stable for the synchronizer.
    task automatic edge_step(input logic e, input logic b, input logic rd);
        for (int h = 0; h < HOLD; h++) begin
            en = 1'b0; ser = b; host.Rx_Read = 1'b0;
            @(posedge clk); #1;
            m_ferr = 1'b0;
        end
        en = e; ser = b; host.Rx_Read = rd;
        @(posedge clk); #1;
        m_ferr = 1'b0;
        if (rd && m_ready) begin
            m_ready = 1'b0;
            m_perr  = 1'b0;
            m_ovr   = 1'b0;
        end
        en = 1'b0; host.Rx_Read = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) edge_step(1'b1, 1'b1, 1'b0);
    endtask

    task automatic read_pulse();
        edge_step(1'b1, 1'b1, 1'b1);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic bad_par, input logic stop_b,
                              input logic rd_stop, input logic toggle, input int nbits);
        logic [W+2:0] bits;
        logic         rdy0;
        logic         junk;
        bits = {stop_b, (^d) ^ bad_par, d, 1'b0};
        for (int k = 0; k < nbits; k++) begin
            if (toggle) begin
                junk = (HOLD > 0) ? bits[k] : 1'($urandom);
                edge_step(1'b0, junk, 1'($urandom));
            end
            rdy0 = m_ready;
            edge_step(1'b1, bits[k], (k == W + 2) ? rd_stop : 1'b0);
            if (k < W + 2) begin
                m_busy = 1'b1;
            end else begin
                m_busy = 1'b0;
                if (stop_b) begin
                    if (!rdy0 || rd_stop) begin
                        m_data  = d;
                        m_ready = 1'b1;
                        m_perr  = bad_par;
                        m_ovr   = 1'b0;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else begin
                    m_ferr = 1'b1;
                end
            end
        end
    endtask

    initial begin
        host.Rx_Read = 1'b0;
        check_on = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(3);

        send_frame(32'hA5A50F0F, 1'b0, 1'b1, 1'b0, 1'b0, W + 3);
        chk("lit_a5_data",  host.Rx_Data, 32'hA5A50F0F);
        chk("lit_a5_ready", 32'(host.Rx_Data_Ready), 32'd1);
        chk("lit_a5_perr",  32'(host.Rx_Parity_Error), 32'd0);
        chk("lit_a5_busy",  32'(host.Rx_Busy), 32'd0);
        read_pulse();

        send_frame(32'h00000001, 1'b1, 1'b1, 1'b0, 1'b0, W + 3);
        chk("lit_par_data", host.Rx_Data, 32'h00000001);
        chk("lit_par_perr", 32'(host.Rx_Parity_Error), 32'd1);
        read_pulse();
        chk("lit_par_clr_ready", 32'(host.Rx_Data_Ready), 32'd0);
        chk("lit_par_clr_perr",  32'(host.Rx_Parity_Error), 32'd0);

        send_frame(32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, W + 3);
        chk("lit_fe_pulse", 32'(host.Rx_Frame_Error), 32'd1);
        chk("lit_fe_ready", 32'(host.Rx_Data_Ready), 32'd0);
        chk("lit_fe_data",  host.Rx_Data, 32'h00000001);
        idle(1);
        chk("lit_fe_gone",  32'(host.Rx_Frame_Error), 32'd0);

        send_frame(32'h11111111, 1'b0, 1'b1, 1'b0, 1'b0, W + 3);
        send_frame(32'h22222222, 1'b0, 1'b1, 1'b0, 1'b0, W + 3);
        chk("lit_ovr_data", host.Rx_Data, 32'h11111111);
        chk("lit_ovr_flag", 32'(host.Rx_Overrun), 32'd1);
        send_frame(32'h22222222, 1'b0, 1'b1, 1'b1, 1'b0, W + 3);
        chk("lit_rd_data",  host.Rx_Data, 32'h22222222);
        chk("lit_rd_ovr",   32'(host.Rx_Overrun), 32'd0);
        read_pulse();

        send_frame(32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b1, W + 3);
        chk("lit_tog_data", host.Rx_Data, 32'hDEADBEEF);
        read_pulse();

        send_frame(32'h0F0F0F0F, 1'b0, 1'b1, 1'b0, 1'b0, 11);
        rst = 1'b0;
        m_data = '0; m_ready = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(2);
        send_frame(32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0, W + 3);
        chk("lit_rst_data", host.Rx_Data, 32'hCAFEF00D);

        for (int f = 0; f < 24; f++) begin
            logic [W-1:0] d;
            d = $urandom;
            send_frame(d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) != 0),
                       1'($urandom), ($urandom_range(0, 3) == 0), W + 3);
            for (int g = $urandom_range(0, 3); g > 0; g--)
                edge_step(1'b1, 1'b1, ($urandom_range(0, 2) == 0));
        end

        idle(2);
        check_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete, expected completion before 2000000");
        $fatal(1);
    end
endmodule
